// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and its bench:
// opcodes, FSM encoding, default latencies and the latency-select helper.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int LAT_ALU_DEF = 1;
  localparam int LAT_MUL_DEF = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
  } op_t;

  // Wait-counter preload: multiply uses its own latency, everything else
  // (including illegal opcodes) is timed like a plain ALU op.
  function automatic logic [7:0] op_latency(input logic [3:0] sel,
                                            input int lat_alu,
                                            input int lat_mul);
    if (sel == OP_MUL) return 8'(lat_mul - 1);
    else               return 8'(lat_alu - 1);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. Grant is combinational from valid and only
// offered while en is high; the pointer remembers who was granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  // last = 1 means requester 1 was granted most recently
  logic last;

  // Pick the single valid requester, or on a tie the one not served last
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  // Pointer follows every accepted grant; reset favours requester 0 first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One operation is in
// flight at a time: accept -> issue -> wait for latency -> hold response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int LAT_ALU = LAT_ALU_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_sel,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out
);

  state_e      state;
  op_t         op_q;
  logic        owner_q;
  logic [7:0]  cnt;
  logic [31:0] result_q;

  logic [1:0]  grant;
  logic        idle;
  logic        in_resp;
  logic        rsp_fire;
  op_t         op_in;

  assign idle    = (state == ST_IDLE);
  assign in_resp = (state == ST_RESP);

  // Readies are offered only in IDLE and never while reset is asserted,
  // since IDLE is also the state held during reset
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({req1_valid, req0_valid}),
    .en    (idle & rst_n),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Capture whichever requester won this cycle
  always_comb begin
    op_in = '{a: req0_a, b: req0_b, sel: req0_sel};
    if (grant[1]) op_in = '{a: req1_a, b: req1_b, sel: req1_sel};
  end

  // ALU sees zero when idle, otherwise the captured operation held steady
  assign alu_a   = idle ? '0 : op_q.a;
  assign alu_b   = idle ? '0 : op_q.b;
  assign alu_sel = idle ? '0 : op_q.sel;

  // Only the owner sees a response; the other side reads valid 0, data 0
  assign rsp0_valid = in_resp & ~owner_q;
  assign rsp1_valid = in_resp &  owner_q;
  assign rsp0_data  = rsp0_valid ? result_q : '0;
  assign rsp1_data  = rsp1_valid ? result_q : '0;
  assign rsp_fire   = owner_q ? rsp1_ready : rsp0_ready;

  // Operation sequencer: accept, issue, count down latency, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      owner_q  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|grant) begin
            op_q    <= op_in;
            owner_q <= grant[1];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= op_latency(op_q.sel, LAT_ALU, LAT_MUL);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 8'd0) begin
            result_q <= alu_out;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (rsp_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int LA = 2;
  localparam int LM = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic signed [31:0] mul_p;

  int checks = 0;
  int failures = 0;
  int edges;
  logic st, hold, noresp;

  always #5 clk = ~clk;

  alu_arbiter #(.LAT_ALU(LA), .LAT_MUL(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  // External ALU: combinational, so any configured latency is satisfied
  always_comb begin
    alu_out = '0;
    mul_p   = $signed(alu_a[15:0]) * $signed(alu_b[15:0]);
    case (alu_sel)
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_ADD: alu_out = alu_a + alu_b;
      OP_SUB: alu_out = alu_a - alu_b;
      OP_SHR: alu_out = alu_a >> alu_b[4:0];
      OP_SHL: alu_out = alu_a << alu_b[4:0];
      OP_MUL: alu_out = mul_p;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic consume();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  // First tick is the accept edge; counts edges until the owner's response
  // appears, and tracks that the ALU drive and both readies stay put.
  task automatic run_op(input int who, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [3:0] es, output int n, output logic stable);
    n = 0;
    stable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) begin
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        #1;
      end
      n++;
      if (alu_a !== ea || alu_b !== eb || alu_sel !== es ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) stable = 1'b0;
      if ((who == 0 ? rsp0_valid : rsp1_valid) === 1'b1) return;
    end
    n = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_a = 0; req1_b = 0; req1_sel = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset state: everything 0 even with requests pending
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_data", rsp0_data | rsp1_data, 0);
    chk("rst_alu", alu_a | alu_b | 32'(alu_sel), 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single requester add 5+3
    req0_a = 5; req0_b = 3; req0_sel = OP_ADD; req0_valid = 1;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_req1_ready", 32'(req1_ready), 0);
    run_op(0, 5, 3, OP_ADD, edges, st);
    chk("t1_latency", edges, LA + 2);
    chk("t1_data", rsp0_data, 8);
    chk("t1_rsp1_valid", 32'(rsp1_valid), 0);
    chk("t1_stable", 32'(st), 1);
    consume();
    #1;
    chk("t1_rsp0_done", 32'(rsp0_valid), 0);
    chk("t1_alu_idle", 32'(alu_sel), 0);

    // Tie after reset: req0 sub first, then req1 xor wins the next tie
    do_reset();
    req0_a = 10; req0_b = 4; req0_sel = OP_SUB; req0_valid = 1;
    req1_a = 32'hF0; req1_b = 32'hFF; req1_sel = OP_XOR; req1_valid = 1;
    #1;
    chk("t2_tie_req0", 32'(req0_ready), 1);
    chk("t2_tie_req1", 32'(req1_ready), 0);
    run_op(0, 10, 4, OP_SUB, edges, st);
    chk("t2_latency0", edges, LA + 2);
    chk("t2_data0", rsp0_data, 6);
    chk("t2_rsp1_data", rsp1_data, 0);
    chk("t2_busy0", 32'(st), 1);
    req0_a = 1; req0_b = 1; req0_sel = OP_ADD; req0_valid = 1;
    consume();
    #1;
    chk("t2_rr_req1", 32'(req1_ready), 1);
    chk("t2_rr_req0", 32'(req0_ready), 0);
    run_op(1, 32'hF0, 32'hFF, OP_XOR, edges, st);
    req0_valid = 0;
    chk("t2_latency1", edges, LA + 2);
    chk("t2_data1", rsp1_data, 32'h0F);
    chk("t2_rsp0_valid", 32'(rsp0_valid), 0);
    chk("t2_busy1", 32'(st), 1);
    consume();

    // Booth multiply -3 * 7 from requester 1
    req1_a = 32'hFFFF_FFFD; req1_b = 7; req1_sel = OP_MUL; req1_valid = 1;
    #1;
    chk("t3_req1_ready", 32'(req1_ready), 1);
    run_op(1, 32'hFFFF_FFFD, 7, OP_MUL, edges, st);
    chk("t3_latency", edges, LM + 2);
    chk("t3_data", rsp1_data, 32'hFFFF_FFEB);
    chk("t3_stable", 32'(st), 1);
    consume();

    // Response backpressure for 10 cycles; non-owner ready ignored
    req0_a = 3; req0_b = 5; req0_sel = OP_XOR; req0_valid = 1;
    #1;
    run_op(0, 3, 5, OP_XOR, edges, st);
    chk("t4_data", rsp0_data, 6);
    req1_a = 1; req1_b = 1; req1_sel = OP_ADD; req1_valid = 1; rsp1_ready = 1;
    hold = 1'b1;
    repeat (10) begin
      tick();
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd6 || req1_ready !== 1'b0 ||
          rsp1_valid !== 1'b0 || alu_sel !== OP_XOR) hold = 1'b0;
    end
    chk("t4_hold", 32'(hold), 1);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("t4_idle_req1", 32'(req1_ready), 1);
    req1_valid = 0;
    #1;
    chk("t4_drop_ready", 32'(req1_ready), 0);
    tick();
    chk("t4_drop_noaccept", 32'(alu_sel), 0);

    // Reset mid-WAIT aborts a multiply and restores the tie pointer
    req0_a = 2; req0_b = 3; req0_sel = OP_MUL; req0_valid = 1;
    #1;
    chk("t5_req0_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0; req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_rst_alu", alu_a | alu_b | 32'(alu_sel), 0);
    chk("t5_rst_ready", {30'd0, req1_ready, req0_ready}, 0);
    chk("t5_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    noresp = 1'b1;
    repeat (30) begin
      tick();
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_sel !== 4'd0) noresp = 1'b0;
    end
    chk("t5_no_resp", 32'(noresp), 1);

    // Tie after reset grants req0; its illegal opcode yields 0
    req0_a = 5; req0_b = 3; req0_sel = 4'd0; req0_valid = 1;
    req1_a = 1; req1_b = 2; req1_sel = OP_ADD; req1_valid = 1;
    #1;
    chk("t5_tie_req0", 32'(req0_ready), 1);
    chk("t5_tie_req1", 32'(req1_ready), 0);
    run_op(0, 5, 3, 4'd0, edges, st);
    req1_valid = 0;
    chk("t6_latency", edges, LA + 2);
    chk("t6_data", rsp0_data, 0);
    chk("t6_stable", 32'(st), 1);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
